// File: rtl/if_id_pkg.sv
// Shared types and constants for the IF/ID pipeline register.
// Holds the fetch-group layout, the default NOP encoding and the occupancy states.
package if_id_pkg;

  localparam int LANES_MAX   = 4;
  localparam int INSTR_BYTES = 4;
  localparam int PC_W_MAX    = 64;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  // Widest fetch group; narrower configurations use the low lanes only.
  typedef struct packed {
    logic [PC_W_MAX-1:0]                       pc;
    logic [LANES_MAX-1:0]                      lane_valid;
    logic [LANES_MAX-1:0][INSTR_BYTES*8-1:0]   instr;
  } fetch_group_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

  function automatic int group_bytes(input int lanes, input int instr_w);
    return lanes * (instr_w / 8);
  endfunction

endpackage

// File: rtl/if_id_skid_slot.sv
// One valid+payload storage slot with load and clear; clear wins over load.
// On clear the payload takes clr_d so the owner decides what a cleared slot shows.
module if_id_skid_slot #(
  parameter int           W       = 8,
  parameter logic [W-1:0] RST_VAL = {W{1'b0}}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clr,
  input  logic [W-1:0] d,
  input  logic [W-1:0] clr_d,
  output logic         valid,
  output logic [W-1:0] q
);

  logic         valid_r;
  logic [W-1:0] q_r;

  // Slot storage: async reset, then clear, then load, else hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r <= 1'b0;
      q_r     <= RST_VAL;
    end else if (clr) begin
      valid_r <= 1'b0;
      q_r     <= clr_d;
    end else if (load) begin
      valid_r <= 1'b1;
      q_r     <= d;
    end else begin
      valid_r <= valid_r;
      q_r     <= q_r;
    end
  end

  assign valid = valid_r;
  assign q     = q_r;

endmodule

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register with valid/ready handshake, optional 2-entry skid,
// multi-lane fetch groups, kill with NOP insertion and a saturating bubble counter.
import if_id_pkg::*;

module if_id_pipe_reg #(
  parameter int                 INSTR_W   = 32,
  parameter int                 PC_W      = 64,
  parameter int                 LANES     = 1,
  parameter bit                 SKID_EN   = 1'b1,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEFAULT),
  parameter int                 CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*INSTR_W-1:0] instruction_in,
  input  logic [LANES-1:0]         lane_valid_in,
  input  logic [PC_W-1:0]          pc,
  input  logic                     PCSrcD_Control,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*INSTR_W-1:0] instruction_out,
  output logic [LANES-1:0]         lane_valid_out,
  output logic [PC_W-1:0]          out_pc,
  output logic [PC_W-1:0]          out_pc_next,
  output logic [CNT_W-1:0]         perf_bubbles
);

  localparam int                     GRP_W       = PC_W + LANES + LANES * INSTR_W;
  localparam logic [LANES*INSTR_W-1:0] NOP_GROUP = {LANES{NOP_INSTR}};
  localparam logic [GRP_W-1:0]       RST_PAYLOAD = {{PC_W{1'b0}}, {LANES{1'b0}}, NOP_GROUP};
  localparam logic [PC_W-1:0]        PC_STEP     = PC_W'(group_bytes(LANES, INSTR_W));

  pipe_state_e              state_r, state_next_s;
  logic                     kill_s, accept_s;
  logic                     main_load_s, main_clr_s, main_from_skid_s;
  logic                     skid_load_s, skid_clr_s;
  logic                     main_valid_s, skid_valid_s;
  logic [GRP_W-1:0]         main_q_s, skid_q_s, main_d_s, main_clr_d_s, in_grp_s;
  logic [LANES*INSTR_W-1:0] in_instr_s;
  logic [CNT_W-1:0]         bubbles_r;

  assign kill_s   = flush | PCSrcD_Control;
  assign accept_s = in_valid & in_ready;

  // Lanes marked invalid are stored as NOP so decode never sees stale bits.
  always_comb begin
    in_instr_s = NOP_GROUP;
    for (int i = 0; i < LANES; i++) begin
      in_instr_s[i*INSTR_W +: INSTR_W] = lane_valid_in[i] ? instruction_in[i*INSTR_W +: INSTR_W]
                                                          : NOP_INSTR;
    end
  end

  assign in_grp_s     = {pc, lane_valid_in, in_instr_s};
  assign main_d_s     = main_from_skid_s ? skid_q_s : in_grp_s;
  // A cleared main slot shows NOP with no lanes valid but keeps the last PC.
  assign main_clr_d_s = {main_q_s[GRP_W-1 -: PC_W], {LANES{1'b0}}, NOP_GROUP};

  // Occupancy state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and slot control; kill overrides every other transition.
  always_comb begin
    state_next_s     = state_r;
    main_load_s      = 1'b0;
    main_clr_s       = 1'b0;
    main_from_skid_s = 1'b0;
    skid_load_s      = 1'b0;
    skid_clr_s       = 1'b0;
    if (kill_s) begin
      state_next_s = EMPTY;
      main_clr_s   = 1'b1;
      skid_clr_s   = 1'b1;
    end else begin
      case (state_r)
        EMPTY: begin
          if (accept_s) begin
            main_load_s  = 1'b1;
            state_next_s = ONE;
          end else begin
            state_next_s = EMPTY;
          end
        end
        ONE: begin
          if (accept_s && out_ready) begin
            main_load_s  = 1'b1;
            state_next_s = ONE;
          end else if (accept_s && SKID_EN) begin
            skid_load_s  = 1'b1;
            state_next_s = FULL;
          end else if (out_ready) begin
            main_clr_s   = 1'b1;
            state_next_s = EMPTY;
          end else begin
            state_next_s = ONE;
          end
        end
        FULL: begin
          if (out_ready) begin
            main_load_s      = 1'b1;
            main_from_skid_s = 1'b1;
            skid_clr_s       = 1'b1;
            state_next_s     = ONE;
          end else begin
            state_next_s = FULL;
          end
        end
        default: begin
          main_clr_s   = 1'b1;
          skid_clr_s   = 1'b1;
          state_next_s = EMPTY;
        end
      endcase
    end
  end

  if_id_skid_slot #(.W(GRP_W), .RST_VAL(RST_PAYLOAD)) u_main (
    .clk   (clk),
    .rst   (rst),
    .load  (main_load_s),
    .clr   (main_clr_s),
    .d     (main_d_s),
    .clr_d (main_clr_d_s),
    .valid (main_valid_s),
    .q     (main_q_s)
  );

  if (SKID_EN) begin : g_skid
    if_id_skid_slot #(.W(GRP_W), .RST_VAL(RST_PAYLOAD)) u_skid (
      .clk   (clk),
      .rst   (rst),
      .load  (skid_load_s),
      .clr   (skid_clr_s),
      .d     (in_grp_s),
      .clr_d (RST_PAYLOAD),
      .valid (skid_valid_s),
      .q     (skid_q_s)
    );
    assign in_ready = ~skid_valid_s;
  end else begin : g_no_skid
    assign skid_valid_s = 1'b0;
    assign skid_q_s     = RST_PAYLOAD;
    assign in_ready     = ~main_valid_s | out_ready;
  end

  // Bubble counter: counts cycles with nothing presented, sticks at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bubbles_r <= {CNT_W{1'b0}};
    end else if (!main_valid_s && (bubbles_r != {CNT_W{1'b1}})) begin
      bubbles_r <= bubbles_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      bubbles_r <= bubbles_r;
    end
  end

  assign out_valid       = main_valid_s;
  assign instruction_out = main_q_s[LANES*INSTR_W-1:0];
  assign lane_valid_out  = main_q_s[LANES*INSTR_W +: LANES];
  assign out_pc          = main_q_s[GRP_W-1 -: PC_W];
  assign out_pc_next     = out_pc + PC_STEP;
  assign perf_bubbles    = bubbles_r;

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Directed bench for if_id_pipe_reg: a default 1-lane skid instance and a
// 2-lane, no-skid, 4-bit-counter instance sharing clock and reset.
module tb_if_id_pipe_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  int          n_vec = 0;
  int          n_err = 0;

  // Instance 1: defaults (LANES=1, SKID_EN=1, CNT_W=16)
  logic        in_valid, in_ready, out_valid, out_ready, pcsrc, flush;
  logic [31:0] instruction_in, instruction_out;
  logic [0:0]  lane_valid_in, lane_valid_out;
  logic [63:0] pc, out_pc, out_pc_next;
  logic [15:0] perf_bubbles;

  // Instance 2: LANES=2, SKID_EN=0, CNT_W=4
  logic        in_valid2, in_ready2, out_valid2, out_ready2;
  logic [63:0] instruction_in2, instruction_out2;
  logic [1:0]  lane_valid_in2, lane_valid_out2;
  logic [63:0] pc2, out_pc2, out_pc_next2;
  logic [3:0]  perf_bubbles2;

  always #5 clk = ~clk;

  if_id_pipe_reg u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instruction_in(instruction_in), .lane_valid_in(lane_valid_in), .pc(pc),
    .PCSrcD_Control(pcsrc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .instruction_out(instruction_out), .lane_valid_out(lane_valid_out), .out_pc(out_pc),
    .out_pc_next(out_pc_next), .perf_bubbles(perf_bubbles)
  );

  if_id_pipe_reg #(.LANES(2), .SKID_EN(1'b0), .CNT_W(4)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .instruction_in(instruction_in2), .lane_valid_in(lane_valid_in2), .pc(pc2),
    .PCSrcD_Control(1'b0), .flush(1'b0), .out_valid(out_valid2), .out_ready(out_ready2),
    .instruction_out(instruction_out2), .lane_valid_out(lane_valid_out2), .out_pc(out_pc2),
    .out_pc_next(out_pc_next2), .perf_bubbles(perf_bubbles2)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [63:0] p);
    in_valid = v; instruction_in = ins; lane_valid_in = 1'b1; pc = p;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b1; instruction_in = 32'hCAFE_0001; lane_valid_in = 1'b1;
    pc = 64'h40; out_ready = 1'b0; pcsrc = 1'b0; flush = 1'b0;
    in_valid2 = 1'b0; instruction_in2 = 64'h0; lane_valid_in2 = 2'b00; pc2 = 64'h0; out_ready2 = 1'b0;
    tick(); tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_vec++; if (instruction_out !== 32'h0000_0013) begin n_err++; $display("FAIL reset_instr: got %h want 00000013", instruction_out); end
    n_vec++; if (lane_valid_out !== 1'b0) begin n_err++; $display("FAIL reset_lane_valid: got %b want 0", lane_valid_out); end
    n_vec++; if (out_pc !== 64'h0) begin n_err++; $display("FAIL reset_out_pc: got %h want 0", out_pc); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_vec++; if (perf_bubbles !== 16'd0) begin n_err++; $display("FAIL reset_bubbles: got %0d want 0", perf_bubbles); end
    rst = 1'b1; in_valid = 1'b0;
    tick();
    n_vec++; if (perf_bubbles !== 16'd1) begin n_err++; $display("FAIL bubbles_1: got %0d want 1", perf_bubbles); end
    tick();
    n_vec++; if (perf_bubbles !== 16'd2) begin n_err++; $display("FAIL bubbles_2: got %0d want 2", perf_bubbles); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    drive(1'b1, 32'h1122_3344, 64'h1234_5678_90AB_CDEF);
    tick();
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", out_valid); end
    n_vec++; if (instruction_out !== 32'h1122_3344) begin n_err++; $display("FAIL single_instr: got %h want 11223344", instruction_out); end
    n_vec++; if (out_pc !== 64'h1234_5678_90AB_CDEF) begin n_err++; $display("FAIL single_pc: got %h want 1234567890abcdef", out_pc); end
    n_vec++; if (out_pc_next !== 64'h1234_5678_90AB_CDF3) begin n_err++; $display("FAIL single_pc_next: got %h want 1234567890abcdf3", out_pc_next); end
    // Masked lane with all-zero mask: still a valid group, lane stored as NOP.
    drive(1'b1, 32'hDEAD_BEEF, 64'h80); lane_valid_in = 1'b0;
    tick();
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL zero_mask_valid: got %b want 1", out_valid); end
    n_vec++; if (instruction_out !== 32'h0000_0013) begin n_err++; $display("FAIL zero_mask_instr: got %h want 00000013", instruction_out); end
    n_vec++; if (lane_valid_out !== 1'b0) begin n_err++; $display("FAIL zero_mask_lane: got %b want 0", lane_valid_out); end
    n_vec++; if (out_pc !== 64'h80) begin n_err++; $display("FAIL zero_mask_pc: got %h want 80", out_pc); end
    in_valid = 1'b0;
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 32'hAAAA_0001, 64'h100);
    tick();
    n_vec++; if (instruction_out !== 32'hAAAA_0001 || out_valid !== 1'b1) begin n_err++; $display("FAIL bp_a_first: got %h/%b want aaaa0001/1", instruction_out, out_valid); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_one: got %b want 1", in_ready); end
    drive(1'b1, 32'hBBBB_0002, 64'h104);
    tick();
    n_vec++; if (instruction_out !== 32'hAAAA_0001) begin n_err++; $display("FAIL bp_a_hold: got %h want aaaa0001", instruction_out); end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_full: got %b want 0", in_ready); end
    drive(1'b1, 32'hCCCC_0003, 64'h108);
    tick();
    n_vec++; if (instruction_out !== 32'hAAAA_0001 || out_pc !== 64'h100) begin n_err++; $display("FAIL bp_a_stable: got %h@%h want aaaa0001@100", instruction_out, out_pc); end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_c_stall: got %b want 0", in_ready); end
    out_ready = 1'b1;
    tick();
    n_vec++; if (instruction_out !== 32'hBBBB_0002 || out_pc !== 64'h104) begin n_err++; $display("FAIL bp_b: got %h@%h want bbbb0002@104", instruction_out, out_pc); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_after_drain: got %b want 1", in_ready); end
    tick();
    n_vec++; if (instruction_out !== 32'hCCCC_0003 || out_pc !== 64'h108) begin n_err++; $display("FAIL bp_c: got %h@%h want cccc0003@108", instruction_out, out_pc); end
    in_valid = 1'b0;
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_no_dup: got %b want 0", out_valid); end
  endtask

  task automatic kill_from_full(input bit use_flush, input logic [63:0] base);
    out_ready = 1'b0;
    drive(1'b1, 32'hD000_0001, base);
    tick();
    drive(1'b1, 32'hD000_0002, base + 64'h4);
    tick();
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL kill_pre_full: got %b want 0", in_ready); end
    drive(1'b1, 32'hD000_0003, base + 64'h8);
    if (use_flush) flush = 1'b1; else pcsrc = 1'b1;
    tick();
    flush = 1'b0; pcsrc = 1'b0; in_valid = 1'b0;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL kill_valid(flush=%0d): got %b want 0", use_flush, out_valid); end
    n_vec++; if (instruction_out !== 32'h0000_0013) begin n_err++; $display("FAIL kill_nop(flush=%0d): got %h want 00000013", use_flush, instruction_out); end
    n_vec++; if (lane_valid_out !== 1'b0) begin n_err++; $display("FAIL kill_lane(flush=%0d): got %b want 0", use_flush, lane_valid_out); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL kill_ready(flush=%0d): got %b want 1", use_flush, in_ready); end
    n_vec++; if (out_pc !== base) begin n_err++; $display("FAIL kill_pc_hold(flush=%0d): got %h want %h", use_flush, out_pc, base); end
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL kill_dropped(flush=%0d): got %b want 0", use_flush, out_valid); end
  endtask

  task automatic test_kill();
    kill_from_full(1'b0, 64'h200);
    kill_from_full(1'b1, 64'h300);
    // Beat handshaken while empty in the kill cycle is consumed and dropped.
    drive(1'b1, 32'hE000_0001, 64'h400); flush = 1'b1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL kill_hs_ready: got %b want 1", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_vec++; if (out_valid !== 1'b0 || out_pc !== 64'h300) begin n_err++; $display("FAIL kill_hs_drop: got %b@%h want 0@300", out_valid, out_pc); end
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL kill_hs_late: got %b want 0", out_valid); end
  endtask

  task automatic test_lanes();
    in_valid2 = 1'b1; instruction_in2 = {32'hDEAD_BEEF, 32'h00C0_FFEE};
    lane_valid_in2 = 2'b01; pc2 = 64'hFFFF_FFFF_FFFF_FFFC; out_ready2 = 1'b0;
    tick();
    in_valid2 = 1'b0;
    n_vec++; if (out_valid2 !== 1'b1) begin n_err++; $display("FAIL lanes_valid: got %b want 1", out_valid2); end
    n_vec++; if (instruction_out2 !== 64'h0000_0013_00C0_FFEE) begin n_err++; $display("FAIL lanes_instr: got %h want 0000001300c0ffee", instruction_out2); end
    n_vec++; if (lane_valid_out2 !== 2'b01) begin n_err++; $display("FAIL lanes_mask: got %b want 01", lane_valid_out2); end
    n_vec++; if (out_pc_next2 !== 64'h0000_0000_0000_0004) begin n_err++; $display("FAIL lanes_pc_wrap: got %h want 4", out_pc_next2); end
    n_vec++; if (in_ready2 !== 1'b0) begin n_err++; $display("FAIL noskid_ready_held: got %b want 0", in_ready2); end
    out_ready2 = 1'b1;
    #1;
    n_vec++; if (in_ready2 !== 1'b1) begin n_err++; $display("FAIL noskid_ready_comb: got %b want 1", in_ready2); end
    tick();
    n_vec++; if (out_valid2 !== 1'b0) begin n_err++; $display("FAIL noskid_drain: got %b want 0", out_valid2); end
  endtask

  task automatic test_saturation();
    #2 rst = 1'b0;
    #1;
    n_vec++; if (perf_bubbles2 !== 4'h0) begin n_err++; $display("FAIL async_rst_bubbles: got %h want 0", perf_bubbles2); end
    n_vec++; if (out_valid !== 1'b0 || perf_bubbles !== 16'd0) begin n_err++; $display("FAIL async_rst_main: got %b/%0d want 0/0", out_valid, perf_bubbles); end
    #1 rst = 1'b1;
    tick();
    n_vec++; if (perf_bubbles2 !== 4'h1) begin n_err++; $display("FAIL sat_first: got %h want 1", perf_bubbles2); end
    for (int i = 0; i < 14; i++) tick();
    n_vec++; if (perf_bubbles2 !== 4'hF) begin n_err++; $display("FAIL sat_reach: got %h want f", perf_bubbles2); end
    for (int i = 0; i < 5; i++) tick();
    n_vec++; if (perf_bubbles2 !== 4'hF) begin n_err++; $display("FAIL sat_stick: got %h want f", perf_bubbles2); end
    n_vec++; if (perf_bubbles !== 16'd20) begin n_err++; $display("FAIL wide_count: got %0d want 20", perf_bubbles); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_kill();
    test_lanes();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
